// File: rtl/color_cmd_frontend.sv
// color_cmd_frontend: operator-input stage for the VGA four-quadrant colour generator.
// Synchronises and debounces the board switches and push-keys. A KEY[3] press becomes one
// colour-register write command. A KEY[2] press becomes a 12-command clear sequence. Commands
// leave over a valid/ready handshake.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   SW[17:0]  raw switches: [1:0] quadrant, [3:2] channel (00 B, 01 G, 10 R, 11 illegal),
//             [11:4] value; [17:12] unused
//   KEY[3:0]  raw push-keys, active-low: [3] write, [2] clear-all, [1:0] unused
//   wr_valid  command valid
//   wr_ready  downstream accepts the command this cycle
//   wr_quad   target quadrant
//   wr_chan   target channel
//   wr_data   channel value
//   LEDR      [11:0] synchronised SW, [15:12] one-hot quadrant of last accepted command,
//             [16] sticky illegal-channel error, [17] busy
module color_cmd_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [1:0]  wr_quad,
  output logic [1:0]  wr_chan,
  output logic [7:0]  wr_data,
  output logic [17:0] LEDR
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear, StHold} state_e;

  // Switches [17:12] and keys [1:0] have no function.
  logic unused_inputs;
  assign unused_inputs = ^{SW[17:12], KEY[1:0]};

  // ---------------------------------------------------------------------------------------------
  // Synchronisers. The key chain resets to 0 (pressed), so its reset value can never arm a key.
  // ---------------------------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][11:0] sw_sync_q;
  logic [SYNC_STAGES-1:0][1:0]  key_sync_q;
  logic [11:0]                  sw_s;
  logic [1:0]                   key_s;    // index 0 = KEY[2] clear, 1 = KEY[3] write

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync_q  <= '0;
      key_sync_q <= '0;
    end else begin
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], SW[11:0]};
      key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], KEY[3:2]};
    end
  end

  assign sw_s  = sw_sync_q[SYNC_STAGES-1];
  assign key_s = key_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------------------------
  // Debounce and press detection. A key is only armed once it has been seen released after
  // reset. A key held through reset therefore produces no press until released and pressed again.
  // ---------------------------------------------------------------------------------------------
  logic [1:0]           key_stable_q, key_stable_d;
  logic [1:0]           key_armed_q, key_armed_d;
  logic [1:0][CntW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           press;

  always_comb begin
    key_stable_d = key_stable_q;
    key_armed_d  = key_armed_q | key_s;
    press        = '0;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (key_s[i] != key_stable_q[i]) begin
        if (db_cnt_q[i] == CntMax) begin
          key_stable_d[i] = key_s[i];
          press[i]        = key_stable_q[i] & key_armed_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_stable_q <= '1;
      key_armed_q  <= '0;
      db_cnt_q     <= '0;
    end else begin
      key_stable_q <= key_stable_d;
      key_armed_q  <= key_armed_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [1:0]  lat_quad_q, lat_quad_d;
  logic [1:0]  lat_chan_q, lat_chan_d;
  logic [7:0]  lat_data_q, lat_data_d;
  logic        err_q, err_d;
  logic [3:0]  led_quad_q, led_quad_d;
  logic [11:0] led_sw_q;
  logic        busy_q;
  logic        accept;

  assign accept = wr_valid & wr_ready;

  // Clear sequence: quad = cnt / 3, chan = cnt % 3, as {quad, chan}.
  function automatic logic [3:0] clr_map(input logic [3:0] cnt);
    unique case (cnt)
      4'd0:    clr_map = {2'd0, 2'd0};
      4'd1:    clr_map = {2'd0, 2'd1};
      4'd2:    clr_map = {2'd0, 2'd2};
      4'd3:    clr_map = {2'd1, 2'd0};
      4'd4:    clr_map = {2'd1, 2'd1};
      4'd5:    clr_map = {2'd1, 2'd2};
      4'd6:    clr_map = {2'd2, 2'd0};
      4'd7:    clr_map = {2'd2, 2'd1};
      4'd8:    clr_map = {2'd2, 2'd2};
      4'd9:    clr_map = {2'd3, 2'd0};
      4'd10:   clr_map = {2'd3, 2'd1};
      default: clr_map = {2'd3, 2'd2};
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      lat_quad_q <= '0;
      lat_chan_q <= '0;
      lat_data_q <= '0;
      err_q      <= 1'b0;
      led_quad_q <= '0;
      led_sw_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      lat_quad_q <= lat_quad_d;
      lat_chan_q <= lat_chan_d;
      lat_data_q <= lat_data_d;
      err_q      <= err_d;
      led_quad_q <= led_quad_d;
      led_sw_q   <= sw_s;
      busy_q     <= (state_d != StIdle);
    end
  end

  // Next-state logic. Presses outside StIdle are simply ignored.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    lat_quad_d = lat_quad_q;
    lat_chan_d = lat_chan_q;
    lat_data_d = lat_data_q;
    err_d      = err_q;
    led_quad_d = led_quad_q;
    unique case (state_q)
      StIdle: begin
        if (press[0]) begin
          // Clear wins over a simultaneous write press.
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (press[1]) begin
          if (sw_s[3:2] != 2'b11) begin
            state_d    = StWrite;
            lat_quad_d = sw_s[1:0];
            lat_chan_d = sw_s[3:2];
            lat_data_d = sw_s[11:4];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (accept) state_d = StHold;
      end
      StClear: begin
        if (accept) begin
          if (clr_cnt_q == 4'd11) state_d = StHold;
          else clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      StHold: begin
        if (&key_stable_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      err_d      = 1'b0;
      led_quad_d = 4'b0001 << wr_quad;
    end
  end

  // Outputs
  always_comb begin
    wr_valid = 1'b0;
    wr_quad  = lat_quad_q;
    wr_chan  = lat_chan_q;
    wr_data  = lat_data_q;
    unique case (state_q)
      StWrite: wr_valid = 1'b1;
      StClear: begin
        wr_valid           = 1'b1;
        {wr_quad, wr_chan} = clr_map(clr_cnt_q);
        wr_data            = 8'h00;
      end
      default: wr_valid = 1'b0;
    endcase
  end

  assign LEDR = {busy_q, err_q, led_quad_q, led_sw_q};

endmodule

// File: doc/color_cmd_frontend.md
Name: color_cmd_frontend

Overview:
- Operator-input stage directly upstream of the VGA four-quadrant colour generator.
- Synchronises and debounces the board switches and push-keys, then turns key presses into colour-register write commands.
- Commands go out over a valid/ready handshake and carry a quadrant, a channel (B/G/R) and an 8-bit value.
- Drives LED feedback.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a key level is accepted (10 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SW and KEY; minimum 2.

Ports:
- clk  input  1  50 MHz system clock
- rst  input  1  synchronous reset, active-high
- SW  input  18  raw slide switches. SW[1:0] = quadrant, SW[3:2] = channel (00 B, 01 G, 10 R, 11 illegal), SW[11:4] = value.
- KEY  input  4  raw push-keys, active-low. KEY[3] = write, KEY[2] = clear-all, KEY[1:0] unused.
- wr_valid  output  1  command valid
- wr_ready  input  1  downstream accepts the command this cycle
- wr_quad  output  2  target quadrant 0..3
- wr_chan  output  2  target channel (00 B, 01 G, 10 R)
- wr_data  output  8  channel value
- LEDR  output  18  status LEDs

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - wr_valid=0, wr_quad=0, wr_chan=0, wr_data=0, LEDR=0.
  - Debounced key levels = 1 (released); debounce counters = 0.
  - State = IDLE; clear counter = 0; sticky error = 0.
- Synchroniser: SW and KEY each pass through SYNC_STAGES flops before any use.
- Debounce, per key:
  - Counter resets to 0 whenever the synchronised level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
- Press event: one-cycle pulse when the stable level goes 1->0. Release never generates an event.
- FSM states: IDLE, WRITE, CLEAR, HOLD.
  - IDLE:
    - KEY[2] press → CLEAR, clear counter = 0.
    - Else KEY[3] press with synchronised SW[3:2] != 11 → WRITE. Latch quad, chan and data from the synchronised SW in that same cycle; wr_valid=1 from the next cycle.
    - Else KEY[3] press with SW[3:2] == 11 → set sticky error, stay in IDLE, issue no command.
    - Simultaneous KEY[2] and KEY[3] presses: clear wins; the write is dropped.
  - WRITE: hold wr_valid and all fields stable until the first cycle where wr_valid && wr_ready. Next cycle wr_valid=0 and state → HOLD.
  - CLEAR:
    - Issue 12 commands in order quad 0..3 (outer), chan B, G, R (inner), data = 0.
    - Clear counter is 4 bits, 0..11; quad = cnt/3, chan = cnt%3.
    - Each command holds until accepted. wr_valid stays high across consecutive accepts (back-to-back, one command per ready cycle).
    - After the accept at cnt=11: wr_valid=0, state → HOLD.
  - HOLD: return to IDLE once both debounced KEY[3] and KEY[2] are released (1).
  - Press events arriving outside IDLE are discarded, not queued.
- Latency: press event cycle N → wr_valid high at N+1; with wr_ready held at 1, accepted at N+1, wr_valid low at N+2.
- The clear sequence completes in exactly 12 cycles of asserted wr_ready.
- LEDR, all registered:
  - LEDR[11:0] = synchronised SW[11:0].
  - LEDR[15:12] = one-hot of the quadrant of the last accepted command.
  - LEDR[16] = sticky illegal-channel error; cleared by rst or by any accepted command.
  - LEDR[17] = busy (state != IDLE).
- Reset mid-operation: all outputs return to reset values on the cycle after rst is sampled high. A partial clear is abandoned. Debounce state resets, so a key held through reset yields no event until it is released and pressed again.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- SW[11:0] = 0xAB6 (quad 2, chan G, data 0xAB), KEY[3] low for 10 cycles, wr_ready=1 → exactly one accepted command: wr_quad=2, wr_chan=01, wr_data=0xAB. LEDR[15:12]=0100; LEDR[17] high until KEY[3] released and debounced.
- KEY[3] toggling every 2 cycles for 20 cycles, then steady high → no command ever issued (bounce rejected).
- KEY[2] press, wr_ready=1 → 12 consecutive accepts (0,B)(0,G)(0,R)…(3,R), all with data 0x00; wr_valid low on the 13th cycle.
- Write command with wr_ready=0 for 7 cycles, then 1 → wr_valid and fields unchanged for 7 cycles; single accept on the 8th; new SW values during the stall are ignored.
- SW[3:2]=11, KEY[3] press → no wr_valid, LEDR[16]=1. A following valid write accept → LEDR[16]=0.
- rst=1 at clear-counter 5, then release; second press of KEY[3] only → wr_valid=0 the cycle after rst and LEDR=0. The next command is the single write, not the clear remainder.
